// File: rtl/fd_pipe_stage.sv
// Fetch/decode stage register: PC + instruction over valid/ready,
// optional 2-entry skid buffer, flush-to-NOP and saturating stall counter.
module fd_pipe_stage #(
   parameter int                 PC_W      = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 'hE000,
   parameter int                 SKID      = 1,
   parameter int                 CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic               m_vld_q, m_vld_d;
   logic [PC_W-1:0]    m_pc_q, m_pc_d;
   logic [INSTR_W-1:0] m_instr_q, m_instr_d;
   logic               s_vld_q, s_vld_d;
   logic [PC_W-1:0]    s_pc_q, s_pc_d;
   logic [INSTR_W-1:0] s_instr_q, s_instr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               acc, xfer;

   // With the skid buffer, in_ready depends only on flop state.
   assign in_ready = (SKID != 0) ? ~s_vld_q : (~m_vld_q | out_ready);
   assign acc      = in_valid & in_ready;
   assign xfer     = m_vld_q & out_ready;

   always_comb begin
      m_vld_d   = m_vld_q;
      m_pc_d    = m_pc_q;
      m_instr_d = m_instr_q;
      s_vld_d   = s_vld_q;
      s_pc_d    = s_pc_q;
      s_instr_d = s_instr_q;
      if (flush) begin
         m_vld_d = 1'b0;
         s_vld_d = 1'b0;
      end else if (!m_vld_q || xfer) begin
         if (s_vld_q) begin
            m_vld_d   = 1'b1;
            m_pc_d    = s_pc_q;
            m_instr_d = s_instr_q;
            s_vld_d   = 1'b0;
         end else if (acc) begin
            m_vld_d   = 1'b1;
            m_pc_d    = in_pc;
            m_instr_d = in_instr;
         end else begin
            m_vld_d   = 1'b0;
         end
      end else if (acc && SKID != 0) begin
         s_vld_d   = 1'b1;
         s_pc_d    = in_pc;
         s_instr_d = in_instr;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (m_vld_q && !out_ready && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld_q   <= 1'b0;
         m_pc_q    <= '0;
         m_instr_q <= NOP_INSTR;
         s_vld_q   <= 1'b0;
         s_pc_q    <= '0;
         s_instr_q <= NOP_INSTR;
         cnt_q     <= '0;
      end else begin
         m_vld_q   <= m_vld_d;
         m_pc_q    <= m_pc_d;
         m_instr_q <= m_instr_d;
         s_vld_q   <= s_vld_d;
         s_pc_q    <= s_pc_d;
         s_instr_q <= s_instr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_valid = m_vld_q;
   assign out_pc    = m_pc_q;
   assign out_instr = m_vld_q ? m_instr_q : NOP_INSTR;
   assign stall_cnt = cnt_q;

endmodule

// File: doc/fd_pipe_stage.md
Name: fd_pipe_stage

Overview:
- Parametrised fetch/decode pipeline stage register, the successor to the fixed 16-bit PC/instruction latch.
- Carries a PC and an instruction word between fetch and decode using a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput under backpressure.
- Synchronous flush injects a NOP bubble; a saturating counter reports backpressure stalls for performance monitoring.

Parameters:
- PC_W, 16, width of the PC field
- INSTR_W, 16, width of the instruction field
- NOP_INSTR, 16'hE000, instruction shown on out_instr whenever out_valid=0 (PCS R0)
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CNT_W, 8, width of the stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous flush; discards all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_pc  in  PC_W  upstream PC
- in_instr  in  INSTR_W  upstream instruction
- out_valid  out  1  out_pc/out_instr hold a valid entry
- out_ready  in  1  downstream accepts this cycle
- out_pc  out  PC_W  held PC
- out_instr  out  INSTR_W  held instruction; NOP_INSTR when out_valid=0
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  saturating count of backpressured cycles

Behaviour:
- Reset (async, any time): out_valid=0, out_pc=0, out_instr=NOP_INSTR, skid entry invalid, in_ready=1, stall_cnt=0. An entry in flight during reset is lost.
- Handshake rules:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_pc, out_instr and out_valid come directly from flops, never combinational from the inputs.
  - Latency is 1 cycle: an entry accepted at edge N appears at the output after edge N.
- Held entry is stable: while out_valid=1 and out_ready=0, out_pc/out_instr must not change.
- SKID=1 datapath:
  - Main register M and skid register S; in_ready = ~S.valid, registered.
  - Accept while M is empty or transferring: entry loads into M.
  - Accept while M is valid and not transferring: entry loads into S, so in_ready=0 next cycle.
  - M transfers while S is valid: S moves to M and S is cleared. If an accept coincides, it is impossible because in_ready=0.
  - Order is strict FIFO: entries leave in acceptance order with no duplication or loss.
- SKID=0 datapath:
  - in_ready = ~out_valid | out_ready, combinational.
  - Accept loads M; a transfer with no accept clears out_valid.
- flush (highest priority, below rst):
  - At the next edge, M and S become invalid and in_ready=1 in both modes.
  - An input offered in the flush cycle is dropped, even if in_ready=1.
  - out_instr shows NOP_INSTR from the next cycle.
  - out_pc holds its old value (don't-care for decode).
  - Flush on an already empty stage has no effect.
- out_instr mux: out_instr = out_valid ? M.instr : NOP_INSTR.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr sets it to 0 and takes priority over an increment in the same cycle.
  - flush does not affect the counter.
- Simultaneous events: rst > flush > transfer/accept. cnt_clr is independent of flush.
- Width rules: PC and instruction fields pass through unmodified; no arithmetic is performed on them.

Test Plan:
- Reset, then no inputs: out_valid=0, out_instr=16'hE000, in_ready=1, stall_cnt=0. Assert rst mid-cycle: outputs clear immediately, without waiting for a clock edge.
- Streaming with out_ready=1, in_valid=1, PCs 0x0000, 0x0002, 0x0004 and instrs 0x1111, 0x2222, 0x3333: each appears one cycle after its accept, in_ready stays 1, no bubbles.
- SKID=1 backpressure:
  - Hold out_ready=0 and send A(0x0010/0xAAAA) then B(0x0012/0xBBBB).
  - Output holds A; in_ready drops to 0 after B is accepted; C is not accepted.
  - Release out_ready: A, then B, then C in order.
  - stall_cnt equals the number of stalled cycles.
- Flush with M and S both full plus in_valid=1 carrying D: next cycle out_valid=0, out_instr=0xE000, in_ready=1. D never appears, and A/B never appear afterwards.
- SKID=0 with out_ready=0 and out_valid=1: in_ready=0 combinationally. Raising out_ready in the same cycle as in_valid gives in_ready=1, and the new entry replaces the old at the edge.
- CNT_W=2, hold a stall for 6 cycles: stall_cnt reads 1, 2, 3, 3, 3, 3. Asserting cnt_clr together with a stall gives 0 next cycle.
